// File: rtl/team_07_wb_pkg.sv
// Shared types and default widths for the team_07 Wishbone master and related bus blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package team_07_wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  typedef struct packed {
    logic                   we;
    logic [WB_ADDR_W-1:0]   adr;
    logic [WB_DATA_W-1:0]   dat;
    logic [WB_DATA_W/8-1:0] sel;
  } wbm_req_t;

endpackage

// File: rtl/team_07_wb_timeout.sv
// Loadable saturating cycle counter; flags expiry one cycle after the count reaches TIMEOUT-1.
// Latency: expired rises on the edge after the count reaches TIMEOUT-1 while enabled.
// Backpressure: none; clr has priority over en.
// Ports: clk_i/nrst_i clock and async active-low reset, clr restart, en count enable, expired flag.
module team_07_wb_timeout
  import team_07_wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // The count parks at LAST rather than wrapping; expired is registered so the
  // owning FSM sees it on the following edge, giving TIMEOUT+1 cycles in total.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        expired <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/team_07_wb_master.sv
// Wishbone B4 classic single-transfer master: one user request becomes one bus cycle and one response pulse.
// Latency: response strobe 1 + wait-state cycles after acceptance; TIMEOUT+1 cycles when the slave never answers.
// Backpressure: req_ready_o only in IDLE; the response has no backpressure and must be taken when pulsed.
// Ports: req_* user request (valid/ready), rsp_* one-cycle response, cyc/stb/we/adr/dat/sel/dat_i/ack/err Wishbone side.
module team_07_wb_master
  import team_07_wb_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_adr_i,
  input  logic [DATA_W-1:0]   req_dat_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i,
  input  logic                err_i
);

  localparam int SEL_W = DATA_W / 8;

  wbm_state_t state_q, state_d;

  logic              accept;
  logic              busy;
  logic              expired;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_err_q;

  assign accept = (state_q == IDLE) && req_valid_i;
  assign busy   = (state_q == BUSY);

  team_07_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .clr     (accept),
    .en      (busy),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. ack/err/expiry are only looked at in BUSY, so stray strobes are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = BUSY;
      BUSY:    if (ack_i || err_i || expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are pure state decodes: no path from ack_i to cyc_o, and
  // the async reset drops cyc/stb immediately while raising req_ready_o.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    cyc_o       = busy;
    stb_o       = busy;
    rsp_valid_o = (state_q == RESP);
  end

  // Request register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (accept) begin
      we_q  <= req_we_i;
      adr_q <= req_adr_i;
      dat_q <= req_dat_i;
      sel_q <= req_sel_i;
    end
  end

  // Response register; ack beats both err and a coincident timeout.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (busy) begin
      if (ack_i) begin
        rsp_err_q <= 1'b0;
        rsp_dat_q <= we_q ? '0 : dat_i;
      end else if (err_i || expired) begin
        rsp_err_q <= 1'b1;
        rsp_dat_q <= '0;
      end
    end
  end

  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = sel_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_team_07_wb_master.sv
// Self-checking bench for team_07_wb_master with a scriptable Wishbone slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_team_07_wb_master;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_adr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i;

  always #5 clk_i = ~clk_i;

  team_07_wb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .we_o        (we_o),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .sel_o       (sel_o),
    .dat_i       (dat_i),
    .ack_i       (ack_i),
    .err_i       (err_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        err;
    logic [31:0] rdat;
    int          lat;
    int          stb;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   nchecks = 0;
  int   nfail = 0;
  int   rsp_cnt = 0;
  int   last_acc = 0;

  // Slave model: mode 0 silent, 1 ack, 2 err, 3 ack+err, after slv_nwait wait states.
  int          slv_mode = 0;
  int          slv_nwait = 0;
  logic        slv_echo = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        ack_force = 1'b0;
  int          wcnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (stb_o && !(ack_i || err_i)) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  assign ack_i = (stb_o && wcnt == slv_nwait && (slv_mode == 1 || slv_mode == 3)) || ack_force;
  assign err_i = stb_o && wcnt == slv_nwait && (slv_mode >= 2);
  assign dat_i = slv_echo ? {adr_o[15:0], 16'hBEEF} : slv_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic err, input logic [31:0] rdat,
                          input int lat, input int stb);
    exp_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
    e.err = err; e.rdat = rdat; e.lat = lat; e.stb = stb;
    exp_q.push_back(e);
  endtask

  // Leaves req_valid_i high on return so back-to-back requests can follow.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit track);
    int n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_sel_i   = sel;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      nchecks++;
      nfail++;
      $display("FAIL req_accept actual=not_ready expected=ready adr=%h", adr);
    end else begin
      last_acc = cyc + 1;
      if (track) acc_q.push_back(cyc + 1);
    end
    @(posedge clk_i);
  endtask

  task automatic drop_valid();
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0 || !req_ready_o) begin
      nchecks++;
      nfail++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", exp_q.size());
    end
  endtask

  // Monitor: checks bus fields on the first strobe cycle and every response against the queue head.
  int   stb_len = 0;
  logic in_stb = 1'b0;
  exp_t m_e;
  int   m_a;

  always @(negedge clk_i) begin
    if (!nrst_i) begin
      in_stb = 1'b0;
    end else begin
      if (stb_o) begin
        if (!in_stb) begin
          stb_len = 0;
          in_stb  = 1'b1;
        end
        stb_len++;
        if (stb_len == 1 && exp_q.size() > 0) begin
          chk("bus_cyc", 32'(cyc_o), 32'd1);
          chk("bus_we",  32'(we_o), 32'(exp_q[0].we));
          chk("bus_adr", adr_o, exp_q[0].adr);
          chk("bus_dat", dat_o, exp_q[0].dat);
          chk("bus_sel", 32'(sel_o), 32'(exp_q[0].sel));
        end
      end else begin
        in_stb = 1'b0;
      end
      if (rsp_valid_o) begin
        rsp_cnt++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          nchecks++;
          nfail++;
          $display("FAIL unexpected_rsp actual=rsp_valid expected=none cycle=%0d", cyc);
        end else begin
          m_e = exp_q.pop_front();
          m_a = acc_q.pop_front();
          chk("rsp_err", 32'(rsp_err_o), 32'(m_e.err));
          chk("rsp_dat", rsp_dat_o, m_e.rdat);
          chk("rsp_latency", cyc - m_a, m_e.lat);
          chk("stb_cycles", stb_len, m_e.stb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b_adr [4];
  logic [31:0] b2b_rd  [4];
  int          b2b_acc [4];

  initial begin
    b2b_adr = '{32'h3000_0040, 32'h3000_0044, 32'h3000_0048, 32'h3000_004C};
    b2b_rd  = '{32'h0040_BEEF, 32'h0044_BEEF, 32'h0048_BEEF, 32'h004C_BEEF};

    // Reset values while nrst_i is held low.
    #12;
    chk("rst_cyc",       32'(cyc_o), 32'd0);
    chk("rst_stb",       32'(stb_o), 32'd0);
    chk("rst_we",        32'(we_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err_o), 32'd0);
    chk("rst_adr",       adr_o, 32'd0);
    chk("rst_dat",       dat_o, 32'd0);
    chk("rst_sel",       32'(sel_o), 32'd0);
    chk("rst_rsp_dat",   rsp_dat_o, 32'd0);
    chk("rst_ready",     32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;

    // Zero-wait write.
    slv_mode = 1; slv_nwait = 0;
    push_exp(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1, 1);
    do_req(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
    drop_valid();
    wait_idle();

    // Read with 3 wait states.
    slv_nwait = 3; slv_rdata = 32'h1234_5678;
    push_exp(1'b0, 32'h3000_0008, 32'hAAAA_5555, 4'hF, 1'b0, 32'h1234_5678, 4, 4);
    do_req(1'b0, 32'h3000_0008, 32'hAAAA_5555, 4'hF, 1'b1);
    drop_valid();
    wait_idle();

    // Timeout, then a late ack that must be ignored.
    slv_mode = 0; slv_nwait = 0;
    push_exp(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1'b1, 32'h0, TMO + 1, TMO + 1);
    do_req(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1'b1);
    drop_valid();
    wait_idle();
    @(negedge clk_i);
    ack_force = 1'b1;
    @(negedge clk_i);
    ack_force = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("late_ack_rsp_count", rsp_cnt, 3);
    chk("late_ack_ready", 32'(req_ready_o), 32'd1);

    // Error on a read after one wait state.
    slv_mode = 2; slv_nwait = 1; slv_rdata = 32'hCAFE_F00D;
    push_exp(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1, 32'h0, 2, 2);
    do_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1);
    drop_valid();
    wait_idle();

    // ack and err together: ack wins.
    slv_mode = 3; slv_nwait = 0; slv_rdata = 32'h0BAD_C0DE;
    push_exp(1'b0, 32'h3000_0014, 32'h0, 4'h3, 1'b0, 32'h0BAD_C0DE, 1, 1);
    do_req(1'b0, 32'h3000_0014, 32'h0, 4'h3, 1'b1);
    drop_valid();
    wait_idle();

    // Reset in the middle of a transfer to a silent slave.
    slv_mode = 0;
    do_req(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0);
    drop_valid();
    @(negedge clk_i);
    chk("mid_busy_stb", 32'(stb_o), 32'd1);
    #2;
    nrst_i = 1'b0;
    #1;
    chk("mid_rst_cyc",       32'(cyc_o), 32'd0);
    chk("mid_rst_stb",       32'(stb_o), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_ready",     32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    nrst_i = 1'b1;
    slv_mode = 1;
    push_exp(1'b1, 32'h3000_0024, 32'h1122_3344, 4'h3, 1'b0, 32'h0, 1, 1);
    do_req(1'b1, 32'h3000_0024, 32'h1122_3344, 4'h3, 1'b1);
    drop_valid();
    wait_idle();
    chk("post_rst_rsp_count", rsp_cnt, 6);

    // Back-to-back reads with req_valid_i held high.
    slv_mode = 1; slv_nwait = 0; slv_echo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, b2b_adr[i], 32'h0, 4'hF, 1'b0, b2b_rd[i], 1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, b2b_adr[i], 32'h0, 4'hF, 1'b1);
      b2b_acc[i] = last_acc;
    end
    drop_valid();
    wait_idle();
    for (int i = 1; i < 4; i++) begin
      chk("b2b_spacing", b2b_acc[i] - b2b_acc[i-1], 3);
    end
    repeat (4) @(negedge clk_i);
    chk("total_rsp_count", rsp_cnt, 10);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/team_07_wb_master.md
# team_07_wb_master

Wishbone B4 classic single-transfer bus master (initiator). It converts one-at-a-time read/write requests from user logic into Wishbone cycles toward a slave, such as the team's bus-wrapped design or a loopback slave on the test harness. It returns read data, or an error/timeout status, on a one-cycle response strobe. It sits between team control logic and any `team_07_WB`-style slave.

## Interface
Parameters:
- `ADDR_W`, 32, Wishbone address width
- `DATA_W`, 32, data width; `DATA_W/8` select lanes
- `TIMEOUT`, 255, maximum cycles in the BUSY state without `ack_i`/`err_i` before abort; legal range 1..65535

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge
- `nrst_i`  in  1  reset, asynchronous assert, active-low
- `req_valid_i`  in  1  user request present
- `req_ready_o`  out  1  master can accept a request (IDLE only)
- `req_we_i`  in  1  1 = write, 0 = read
- `req_adr_i`  in  ADDR_W  byte address
- `req_dat_i`  in  DATA_W  write data
- `req_sel_i`  in  DATA_W/8  byte select
- `rsp_valid_o`  out  1  one-cycle response pulse
- `rsp_dat_o`  out  DATA_W  read data; 0 on writes and errors
- `rsp_err_o`  out  1  qualified by `rsp_valid_o`; 1 on `err_i` or timeout
- `cyc_o`, `stb_o`, `we_o`  out  1  Wishbone cycle, strobe and write enable
- `adr_o`  out  ADDR_W; `dat_o`  out  DATA_W; `sel_o`  out  DATA_W/8
- `dat_i`  in  DATA_W; `ack_i`  in  1; `err_i`  in  1

## Operation
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- **IDLE**
  - `req_ready_o`=1.
  - When `req_valid_i && req_ready_o`: register `we/adr/dat/sel`, clear the timeout counter, go to BUSY.
- **BUSY**
  - `cyc_o`=`stb_o`=1; `we_o/adr_o/dat_o/sel_o` hold the captured values.
  - Counter increments each BUSY cycle.
  - `ack_i`=1: capture `dat_i` (reads only), err=0, go to RESP.
  - `err_i`=1 (without `ack_i`): err=1, data=0, go to RESP.
  - `ack_i` and `err_i` both high: treat as `ack_i`.
  - Counter reaches `TIMEOUT-1` with no `ack_i`/`err_i`: err=1, data=0, go to RESP.
  - `ack_i` in the same cycle as the timeout: `ack_i` wins.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle, `cyc_o`=`stb_o`=0, then go to IDLE.
  - There is no response backpressure; the user must accept the pulse.
- The master ignores `ack_i`/`err_i` outside BUSY, so a late ack after a timeout is discarded.
- All outputs are registered or decoded from state only. There is no combinational path from `ack_i` to `cyc_o`.

## Timing
- **Reset:** `nrst_i` low clears everything immediately and asynchronously.
  - state=IDLE.
  - `cyc_o`, `stb_o`, `we_o`, `rsp_valid_o`, `rsp_err_o` = 0.
  - `adr_o`, `dat_o`, `sel_o`, `rsp_dat_o` = 0.
  - `req_ready_o`=1 while `nrst_i` is low, so the IDLE decode is true during reset.
- **Reset mid-transfer:** `cyc_o`/`stb_o` drop without waiting for the clock, and no response is issued.
- **Edge E0:** request accepted; `cyc_o`/`stb_o` are high from E0 until the ack edge.
- **Zero-wait-state slave:** `ack_i` sampled at E1; `rsp_valid_o` high in cycle E1..E2; `req_ready_o` high again after E2.
  - Minimum request-to-request spacing is 3 cycles.
- **Wait states:** each wait state adds one cycle.
- **Timeout:** `rsp_valid_o` asserts `TIMEOUT+1` cycles after acceptance.
- **Counter:** width is `$clog2(TIMEOUT+1)`; it never wraps because it saturates at `TIMEOUT-1`.
- **Captured data:** `rsp_dat_o` holds its value until the next response. It is defined only while `rsp_valid_o` is high.

## Structure
- Package `team_07_wb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, BUSY, RESP} wbm_state_t`
  - default width constants `WB_ADDR_W`/`WB_DATA_W` = 32
  - a `wbm_req_t` struct with fields we, adr, dat, sel
- Sub-module `team_07_wb_timeout`: a loadable saturating counter.
  - Inputs: `clr`, `en`.
  - Output: `expired` at `TIMEOUT-1`.
  - Reused by other team bus blocks.
- Top FSM, request register and response register stay in `team_07_wb_master`.

## Test plan
- **Zero-wait write:** write adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF against a zero-wait slave.
  - `cyc_o`/`stb_o`/`we_o` high exactly 1 cycle with those values.
  - `rsp_valid_o` 1 cycle, `rsp_err_o`=0.
- **Read with wait states:** read adr=0x3000_0008; slave returns 0x1234_5678 after 3 wait states.
  - `stb_o` high 4 cycles.
  - `rsp_dat_o`=0x1234_5678, `rsp_err_o`=0.
- **Timeout:** `TIMEOUT`=8, slave never acks.
  - `rsp_valid_o` at cycle 9 after accept, `rsp_err_o`=1, `rsp_dat_o`=0.
  - An ack injected 2 cycles later produces no second response.
- **Error response:** slave asserts `err_i` on a read → `rsp_err_o`=1, `rsp_dat_o`=0.
  - `ack_i`+`err_i` together in the same cycle → `rsp_err_o`=0, data captured.
- **Reset mid-transfer:** pull `nrst_i` low during BUSY.
  - `cyc_o`/`stb_o` go to 0 before the next edge, with no `rsp_valid_o`.
  - After release `req_ready_o`=1 and the next request completes normally.
- **Back-to-back requests:** `req_valid_i` held high for 4 requests against a zero-wait slave.
  - Exactly 4 responses, spaced 3 cycles apart, in request order.
